// File: rtl/stim_sequencer_pkg.sv
// Shared types and constants for the stimulus sequencer: FSM state encoding,
// vector count and the fixed {a,b,c} pattern table.
package stim_sequencer_pkg;

    localparam int unsigned NUM_VEC = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Entry i occupies bits [3i+2:3i]; order is 000,111,001,010,011,100,101,110.
    localparam logic [3*NUM_VEC-1:0] PATTERN_TABLE = {
        3'b110, 3'b101, 3'b100, 3'b011,
        3'b010, 3'b001, 3'b111, 3'b000
    };

    function automatic logic [2:0] pattern_of(input logic [2:0] idx);
        return PATTERN_TABLE[3*int'(idx) +: 3];
    endfunction

endpackage

// File: rtl/stim_sequencer_dwell_counter.sv
// Dwell timer: counts enabled cycles and flags the last cycle of each dwell,
// wrapping to zero on the enabled terminal cycle so it never exceeds DWELL-1.
module dwell_counter
    import stim_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Drives eight fixed {a,b,c} stimulus vectors, each held DWELL cycles, and
// captures the downstream {d,e} response at the last cycle of every dwell.
module stim_sequencer
    import stim_sequencer_pkg::*;
#(
    parameter int unsigned DWELL   = 100,
    parameter int unsigned NUM_VEC = stim_sequencer_pkg::NUM_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic        d_in,
    input  logic        e_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  vec_idx,
    output logic [15:0] capture,
    output logic        capture_valid
);

    localparam logic [2:0] VEC_LAST = 3'(NUM_VEC - 1);

    state_e      state_q,     state_d;
    logic [2:0]  vec_idx_q,   vec_idx_d;
    logic [2:0]  abc_q,       abc_d;
    logic [15:0] capture_q,   capture_d;
    logic        cap_valid_q, cap_valid_d;

    logic accept;
    logic step;
    logic tc;

    assign accept = (state_q == S_IDLE) && start;
    assign step   = (state_q == S_RUN) && !pause;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (step),
        .tc    (tc)
    );

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        abc_d       = abc_q;
        capture_d   = capture_q;
        cap_valid_d = cap_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    vec_idx_d   = '0;
                    abc_d       = pattern_of(3'd0);
                    capture_d   = '0;
                    cap_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                // The response sampled here belongs to the vector still on a/b/c.
                if (step && tc) begin
                    capture_d[{vec_idx_q, 1'b0} +: 2] = {d_in, e_in};
                    if (vec_idx_q == VEC_LAST) begin
                        state_d     = S_DONE;
                        abc_d       = '0;
                        cap_valid_d = 1'b1;
                    end else begin
                        vec_idx_d = vec_idx_q + 3'd1;
                        abc_d     = pattern_of(vec_idx_q + 3'd1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_idx_q   <= '0;
            abc_q       <= '0;
            capture_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            abc_q       <= abc_d;
            capture_q   <= capture_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign {a, b, c}     = abc_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign vec_idx       = vec_idx_q;
    assign capture       = capture_q;
    assign capture_valid = cap_valid_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: a DWELL=4 and a DWELL=1 instance, each fed by a
// lookup-table model of the downstream stage, checked against a dwell-time model.
module tb_stim_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic start_r = 1'b0;
    logic pause_r = 1'b0;

    logic [1:0] lut [8];
    logic [2:0] ref_pat [8] = '{3'b000, 3'b111, 3'b001, 3'b010,
                                3'b011, 3'b100, 3'b101, 3'b110};

    logic start4, pause4, a4, b4, c4, d4, e4, busy4, done4, cv4;
    logic start1, pause1, a1, b1, c1, d1, e1, busy1, done1, cv1;
    logic [2:0]  vidx4, vidx1;
    logic [15:0] cap4, cap1;

    logic [2:0]  o_abc, o_vidx;
    logic        o_busy, o_done, o_cv;
    logic [15:0] o_cap;
    logic [15:0] last_cap = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start4 = !sel && start_r;
    assign pause4 = !sel && pause_r;
    assign start1 = sel && start_r;
    assign pause1 = sel && pause_r;
    assign {d4, e4} = lut[{a4, b4, c4}];
    assign {d1, e1} = lut[{a1, b1, c1}];

    assign o_abc  = sel ? {a1, b1, c1} : {a4, b4, c4};
    assign o_vidx = sel ? vidx1 : vidx4;
    assign o_busy = sel ? busy1 : busy4;
    assign o_done = sel ? done1 : done4;
    assign o_cv   = sel ? cv1 : cv4;
    assign o_cap  = sel ? cap1 : cap4;

    stim_sequencer #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .pause(pause4),
        .a(a4), .b(b4), .c(c4), .d_in(d4), .e_in(e4),
        .busy(busy4), .done(done4), .vec_idx(vidx4),
        .capture(cap4), .capture_valid(cv4)
    );

    stim_sequencer #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause1),
        .a(a1), .b(b1), .c(c1), .d_in(d1), .e_in(e1),
        .busy(busy1), .done(done1), .vec_idx(vidx1),
        .capture(cap1), .capture_valid(cv1)
    );

    function automatic logic [15:0] exp_capture();
        logic [15:0] r = '0;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = lut[ref_pat[i]];
        return r;
    endfunction

    task automatic set_lut_and_or();
        for (int v = 0; v < 8; v++) begin
            logic [2:0] x = 3'(v);
            lut[v] = {x[2] & x[1], x[1] | x[0]};
        end
    endtask

    task automatic set_lut_random();
        for (int v = 0; v < 8; v++) lut[v] = 2'($urandom_range(3));
    endtask

    // t counts unpaused RUN edges since start; vector = t/DWELL, done once t = 8*DWELL.
    task automatic run_check(input logic s, input int pct, input int pstart, input int plen,
                             input logic first_pause, input logic poke, input int abort_vec);
        int d, t, j;
        logic p, got_done;
        logic [15:0] ec;
        d = s ? 1 : 4;
        t = 0;
        j = 0;
        got_done = 1'b0;
        ec = exp_capture();
        @(negedge clk);
        sel = s;
        start_r = 1'b1;
        pause_r = first_pause;
        p = first_pause;
        while (!got_done && j < 8*d + 64) begin
            @(negedge clk);
            j++;
            if (j >= 2 && !p) t++;
            n_vec++;
            if (t == 8*d) begin
                got_done = 1'b1;
                if ({o_busy, o_done, o_abc, o_cv, o_cap} !== {1'b0, 1'b1, 3'b000, 1'b1, ec}) begin
                    n_bad++;
                    $display("FAIL done_cycle dw=%0d cyc=%0d: got busy=%b done=%b abc=%b valid=%b cap=%h, want 0 1 000 1 %h",
                             d, j, o_busy, o_done, o_abc, o_cv, o_cap, ec);
                end
            end else begin
                if ({o_busy, o_done, o_vidx, o_abc} !== {1'b1, 1'b0, 3'(t/d), ref_pat[t/d]}) begin
                    n_bad++;
                    $display("FAIL run_cycle dw=%0d cyc=%0d: got busy=%b done=%b idx=%0d abc=%b, want 1 0 %0d %b",
                             d, j, o_busy, o_done, o_vidx, o_abc, t/d, ref_pat[t/d]);
                end
                if (j == 1) begin
                    n_vec++;
                    if ({o_cv, o_cap} !== 17'h0) begin
                        n_bad++;
                        $display("FAIL start_clear: got valid=%b cap=%h, want 0 0000", o_cv, o_cap);
                    end
                end
                if (abort_vec >= 0 && t/d == abort_vec) begin
                    #2 rst_n = 1'b0;
                    #1;
                    start_r = 1'b0;
                    pause_r = 1'b0;
                    n_vec++;
                    if ({a4, b4, c4, busy4, done4, vidx4, cap4, cv4, a1, b1, c1, busy1, done1, vidx1, cap1, cv1} !== '0) begin
                        n_bad++;
                        $display("FAIL async_reset: got abc=%b%b%b busy=%b done=%b idx=%0d cap=%h valid=%b, want all 0",
                                 o_abc[2], o_abc[1], o_abc[0], o_busy, o_done, o_vidx, o_cap, o_cv);
                    end
                    repeat (10) begin
                        @(negedge clk);
                        n_vec++;
                        if ({busy4, done4, cv4, busy1, done1, cv1} !== 6'b0) begin
                            n_bad++;
                            $display("FAIL abort_quiet: got busy/done/valid=%b%b%b %b%b%b, want 000 000",
                                     busy4, done4, cv4, busy1, done1, cv1);
                        end
                    end
                    rst_n = 1'b1;
                    return;
                end
            end
            start_r = poke && (j == 4);
            p = ((j >= pstart) && (j < pstart + plen)) || (int'($urandom_range(99)) < pct);
            pause_r = p;
        end
        pause_r = 1'b0;
        start_r = 1'b0;
        if (!got_done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout dw=%0d: got no done within %0d cycles, want done", d, j);
        end
        repeat (poke ? 6 : 1) begin
            @(negedge clk);
            n_vec++;
            if ({o_busy, o_done, o_cv, o_cap} !== {1'b0, 1'b0, 1'b1, ec}) begin
                n_bad++;
                $display("FAIL after_done dw=%0d: got busy=%b done=%b valid=%b cap=%h, want 0 0 1 %h",
                         d, o_busy, o_done, o_cv, o_cap, ec);
            end
        end
        last_cap = ec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({a4, b4, c4, busy4, done4, vidx4, cap4, cv4, a1, b1, c1, busy1, done1, vidx1, cap1, cv1} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got dut4 abc=%b%b%b busy=%b idx=%0d cap=%h valid=%b, want all 0",
                     a4, b4, c4, busy4, vidx4, cap4, cv4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        set_lut_and_or();
        run_check(1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_capture_hold();
        repeat (20) begin
            @(negedge clk);
            n_vec++;
            if ({o_busy, o_done, o_cv, o_cap} !== {1'b0, 1'b0, 1'b1, last_cap}) begin
                n_bad++;
                $display("FAIL capture_hold: got busy=%b done=%b valid=%b cap=%h, want 0 0 1 %h",
                         o_busy, o_done, o_cv, o_cap, last_cap);
            end
        end
    endtask

    task automatic test_pause();
        set_lut_and_or();
        run_check(1'b0, 0, 10, 3, 1'b0, 1'b0, -1);
    endtask

    task automatic test_start_while_busy();
        set_lut_random();
        run_check(1'b0, 0, 0, 0, 1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_run();
        set_lut_random();
        run_check(1'b0, 0, 0, 0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_dwell1();
        set_lut_random();
        run_check(1'b1, 0, 0, 0, 1'b0, 1'b0, -1);
        test_capture_hold();
    endtask

    task automatic test_start_with_pause();
        set_lut_random();
        run_check(1'b0, 0, 1, 1, 1'b1, 1'b0, -1);
        set_lut_random();
        run_check(1'b1, 0, 1, 2, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            set_lut_random();
            run_check(1'(k), 25, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_capture_hold();
        test_pause();
        test_start_while_busy();
        test_reset_mid_run();
        test_dwell1();
        test_start_with_pause();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
